// File: rtl/inst_seq_pkg.sv
// Shared types, opcode class constants and the operand-count helper for the
// instruction sequence decoder.
package inst_seq_pkg;

  // Decoder phases: waiting for an opcode, collecting operand words, holding
  // a complete instruction for the execute stage.
  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_ARG   = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  // Opcode class boundaries (4-bit opcode space, all 16 codes legal).
  localparam logic [3:0] OPC_LD        = 4'h0;
  localparam logic [3:0] OPC_STR       = 4'h1;
  localparam logic [3:0] OPC_SEI       = 4'h2;
  localparam logic [3:0] OPC_SML       = 4'h3;
  localparam logic [3:0] OPC_JMP_FIRST = 4'h4;
  localparam logic [3:0] OPC_JMP_LAST  = 4'h6;
  localparam logic [3:0] OPC_LDD       = 4'h7;
  localparam logic [3:0] OPC_ARI_FIRST = 4'h8;
  localparam logic [3:0] OPC_ARI_LAST  = 4'hB;
  localparam logic [3:0] OPC_LOG_FIRST = 4'hC;
  localparam logic [3:0] OPC_LOG_LAST  = 4'hE;
  localparam logic [3:0] OPC_SMH       = 4'hF;

  // Operand word counts are 0..4, so three bits cover the counter.
  localparam int CNTW = 3;

  // One bit per instruction class, in port order.
  typedef struct packed {
    logic ld;
    logic str;
    logic sei;
    logic sml;
    logic jmp;
    logic ldd;
    logic ari;
    logic w_car;
    logic log_op;
    logic smh;
  } class_flags_t;

  // Number of operand words that follow a given opcode.
  function automatic logic [CNTW-1:0] op_words(input logic [3:0] opc,
                                                input int jmp_words,
                                                input int ldd_words);
    op_words = '0;
    if (opc >= OPC_JMP_FIRST && opc <= OPC_JMP_LAST) begin
      op_words = CNTW'(jmp_words);
    end else if (opc == OPC_LDD) begin
      op_words = CNTW'(ldd_words);
    end
  endfunction

endpackage

// File: rtl/inst_class_dec.sv
// Pure combinational opcode-to-class decode. Gating by issue-valid is done
// by the caller so this block stays a plain lookup.
module inst_class_dec
  import inst_seq_pkg::*;
(
  input  logic [3:0]   opc_i,
  output class_flags_t flags_o
);

  // Map each opcode onto its class flag(s).
  always_comb begin
    flags_o = '0;
    if (opc_i == OPC_LD) begin
      flags_o.ld     = 1'b1;
      flags_o.log_op = 1'b1;
    end
    if (opc_i == OPC_STR) flags_o.str = 1'b1;
    if (opc_i == OPC_SEI) flags_o.sei = 1'b1;
    if (opc_i == OPC_SML) flags_o.sml = 1'b1;
    if (opc_i >= OPC_JMP_FIRST && opc_i <= OPC_JMP_LAST) flags_o.jmp = 1'b1;
    if (opc_i == OPC_LDD) flags_o.ldd = 1'b1;
    if (opc_i >= OPC_ARI_FIRST && opc_i <= OPC_ARI_LAST) begin
      flags_o.ari   = 1'b1;
      flags_o.w_car = opc_i[1];
    end
    if (opc_i >= OPC_LOG_FIRST && opc_i <= OPC_LOG_LAST) flags_o.log_op = 1'b1;
    if (opc_i == OPC_SMH) flags_o.smh = 1'b1;
  end

endmodule

// File: rtl/inst_seq_dec.sv
// Instruction sequence decoder: takes an opcode word followed by 0..4 operand
// words from the fetch stream, assembles them, and holds the decoded
// instruction until the execute stage takes it.
//
// Handshakes: a word moves on IN_* only in a cycle where IN_VALID and
// IN_READY are both 1; an instruction moves on ISSUE_* only in a cycle where
// ISSUE_VALID and ISSUE_READY are both 1. IN_READY may depend combinationally
// on ISSUE_READY and FLUSH (so a new opcode can replace an issuing one with no
// bubble); ISSUE_VALID is purely registered.
module inst_seq_dec
  import inst_seq_pkg::*;
#(
  parameter  int DW        = 4,
  parameter  int JMP_WORDS = 2,
  parameter  int LDD_WORDS = 1,
  localparam int MAXW_JL   = (JMP_WORDS > LDD_WORDS) ? JMP_WORDS : LDD_WORDS,
  localparam int MAXW      = (MAXW_JL > 1) ? MAXW_JL : 1,
  localparam int ARGW      = DW * MAXW,
  localparam int SUBW      = (DW > 4) ? (DW - 4) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [DW-1:0]   IN_DATA,
  input  logic            FLUSH,
  output logic            ISSUE_VALID,
  input  logic            ISSUE_READY,
  output logic [3:0]      OPC,
  output logic [SUBW-1:0] SUB,
  output logic [ARGW-1:0] ARG,
  output logic            LD,
  output logic            STR,
  output logic            SEI,
  output logic            SML,
  output logic            JMP,
  output logic            LDD,
  output logic            ARI,
  output logic            W_CAR,
  output logic            LOG,
  output logic            SMH
);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [3:0]        opc_q, opc_d;
  logic [SUBW-1:0]   sub_q, sub_d;
  logic [ARGW-1:0]   arg_q, arg_d;

  logic [SUBW-1:0]   in_sub;
  logic [CNTW-1:0]   n_new;
  logic [CNTW-1:0]   n_cur;
  logic              in_ready;
  logic              xfer;
  logic              issue_valid;
  class_flags_t      flags_raw;
  class_flags_t      flags;

  // The sub-field only exists for words wider than the opcode.
  if (DW > 4) begin : g_sub
    assign in_sub = IN_DATA[DW-1:4];
  end else begin : g_nosub
    assign in_sub = '0;
  end

  assign n_new = op_words(IN_DATA[3:0], JMP_WORDS, LDD_WORDS);
  assign n_cur = op_words(opc_q, JMP_WORDS, LDD_WORDS);

  // Reset forces IN_READY low even though the state already reads S_OP.
  assign in_ready    = RST && !FLUSH && ((state_q != S_ISSUE) || ISSUE_READY);
  assign xfer        = IN_VALID && in_ready;
  assign issue_valid = (state_q == S_ISSUE);

  // Next-state and datapath update; FLUSH overrides everything but keeps the
  // last opcode/sub-field/operands visible.
  always_comb begin
    logic load_op;
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    sub_d   = sub_q;
    arg_d   = arg_q;
    load_op = 1'b0;

    if (FLUSH) begin
      state_d = S_OP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OP: begin
          if (xfer) load_op = 1'b1;
        end
        S_ARG: begin
          if (xfer) begin
            for (int k = 0; k < MAXW; k++) begin
              if (cnt_q == CNTW'(k)) arg_d[k*DW +: DW] = IN_DATA;
            end
            // Counter stops at N-1; leaving S_ARG is what marks completion.
            if (cnt_q == n_cur - CNTW'(1)) begin
              state_d = S_ISSUE;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (ISSUE_READY) begin
            if (xfer) load_op = 1'b1;
            else      state_d = S_OP;
          end
        end
        default: state_d = S_OP;
      endcase

      if (load_op) begin
        opc_d   = IN_DATA[3:0];
        sub_d   = in_sub;
        arg_d   = '0;
        cnt_d   = '0;
        state_d = (n_new != '0) ? S_ARG : S_ISSUE;
      end
    end
  end

  // State, counter and instruction registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_OP;
      cnt_q   <= '0;
      opc_q   <= '0;
      sub_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      sub_q   <= sub_d;
      arg_q   <= arg_d;
    end
  end

  inst_class_dec u_class_dec (
    .opc_i   (opc_q),
    .flags_o (flags_raw)
  );

  assign flags = issue_valid ? flags_raw : '0;

  assign IN_READY    = in_ready;
  assign ISSUE_VALID = issue_valid;
  assign OPC         = opc_q;
  assign SUB         = sub_q;
  assign ARG         = arg_q;
  assign LD          = flags.ld;
  assign STR         = flags.str;
  assign SEI         = flags.sei;
  assign SML         = flags.sml;
  assign JMP         = flags.jmp;
  assign LDD         = flags.ldd;
  assign ARI         = flags.ari;
  assign W_CAR       = flags.w_car;
  assign LOG         = flags.log_op;
  assign SMH         = flags.smh;

endmodule
